mdio_master_arb: RTL and testbench
==================================

Name: mdio_master_arb

Overview:
- MDIO management master for the clause-22 link, running on MDC.
- Arbitrates between two management requesters, round-robin.
- Latches the winner's command and serializes a full MDIO frame onto mdio_out/mdio_oe: preamble, ST, OP, PHYAD, REGAD, TA, DATA.
- Write frames drive all 16 data bits. Read frames release the line at turnaround and shift 16 bits in from mdio_in.
- Completion is returned as a one-cycle ack to the granted requester. Drives the same line the receptor block listens on.

Parameters:
PREAMBLE_LEN, 32, number of preamble '1' bits driven before ST (legal range 1..63)

Ports:
MDC  in  1  clock; all state updates on posedge MDC
rst  in  1  asynchronous, active-high reset
req_valid  in  2  per-requester request; bit i = requester i
req_write  in  2  per-requester op: 1 = write, 0 = read
req_phy  in  10  PHY address, requester i at [5i+4:5i]
req_reg  in  10  register address, requester i at [5i+4:5i]
req_wdata  in  32  write data, requester i at [16i+15:16i]
gnt  out  2  one-hot grant, high for the whole transaction
ack  out  2  one-cycle completion pulse to the granted requester
rd_data  out  16  read result; valid when ack is high for a read
busy  out  1  high whenever state != IDLE
mdio_out  out  1  serial data to the line
mdio_oe  out  1  output enable for mdio_out
mdio_in  in  1  serial data from the line (read data phase)

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - State goes to IDLE.
  - gnt=0, ack=0, busy=0, rd_data=0, mdio_oe=0, mdio_out=1.
  - Round-robin pointer is set so requester 0 wins the first tie.
  - A transaction in flight is aborted with no ack.
- States: IDLE, PRE, HDR, TA, DATA, DONE. A 6-bit bit counter is used inside each state.
- IDLE:
  - At the posedge where any req_valid bit is high, the arbiter selects a requester.
  - Selection: the single requester if only one is valid. If both are valid, the one not granted last.
  - On that edge: latch op/phy/reg/wdata of the winner, set gnt one-hot, set busy=1, go to PRE.
  - Fields are latched at grant. req_valid may drop afterwards. Later changes to the request inputs are ignored until DONE.
- PRE: PREAMBLE_LEN cycles with mdio_oe=1, mdio_out=1.
- HDR: 14 cycles with mdio_oe=1, MSB first:
  - ST = 01.
  - OP = 01 for write, 10 for read.
  - PHYAD[4:0], then REGAD[4:0].
- TA: 2 cycles.
  - Write: mdio_oe=1, drives 1 then 0.
  - Read: mdio_oe=0, mdio_out=1.
- DATA: 16 cycles.
  - Write: mdio_oe=1, drives wdata[15] first.
  - Read: mdio_oe=0. mdio_in is sampled at the posedge ending each data cycle and shifted in MSB first.
- DONE: 1 cycle.
  - ack[granted]=1.
  - For reads, rd_data updates on entry to DONE and holds until the next read completes. Writes leave rd_data unchanged.
  - mdio_oe=0.
  - The next edge returns to IDLE and clears gnt and busy. No new grant is taken in the DONE cycle.
- Latency: the grant edge is G. Frame bits occupy cycles G+1 .. G+PREAMBLE_LEN+32. ack is high in cycle G+PREAMBLE_LEN+33. At default PREAMBLE_LEN this is 65 cycles after grant.
- Back-to-back: a request held valid through DONE is granted at the first IDLE edge. The minimum gap between frames is 1 IDLE cycle.
- Round-robin pointer updates only at grant. A lone requester may be granted repeatedly.
- All outputs are registered, with no combinational path from inputs to outputs.

Decomposition:
- Shared header mdio_defs.vh:
  - state encodings
  - ST code 2'b01; OP_WR 2'b01; OP_RD 2'b10
  - TA write pattern 2'b10
  - field widths: PHY 5, REG 5, DATA 16
- One sub-module, mdio_rr_arb: a 2-way round-robin arbiter.
  - Inputs: req[1:0], an enable (IDLE), rst.
  - Outputs: registered one-hot gnt and the pointer.
- Framing FSM and shift registers stay in mdio_master_arb.

Test Plan:
- Write from requester 0: phy=5'h01, reg=5'h04, wdata=16'hA5C3 -> after 32 ones, the bitstream 01 01 00001 00100 10 1010010111000011 appears with oe=1 throughout; ack=2'b01 at G+65.
- Read from requester 1: phy=5'h1F, reg=5'h00, mdio_in drives 16'h3C0F during DATA -> oe=0 from the TA start through DATA; ack=2'b10 at G+65 with rd_data=16'h3C0F.
- Both requesters valid from reset, held -> grants alternate 01, 10, 01; each gnt lasts exactly 65 cycles with a 1-cycle IDLE gap between frames.
- rst asserted at HDR bit 7 -> immediately oe=0, gnt=0, busy=0; no ack. After release, the pending request restarts from the preamble.
- PREAMBLE_LEN=1, write 16'h0000 -> ack at G+34; rd_data keeps its previous read value.
- Request fields change after grant -> the frame carries the latched values, not the new ones.

Source files
------------

// File: rtl/mdio_master_arb_pkg.sv
// rtl/mdio_master_arb_pkg.sv - shared MDIO frame constants, state encoding and frame builder
package mdio_master_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_HDR,
        S_TA,
        S_DATA,
        S_DONE
    } state_t;

    localparam logic [1:0] ST_CODE = 2'b01;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_RD   = 2'b10;
    localparam logic [1:0] TA_WR   = 2'b10;

    localparam int PHY_W  = 5;
    localparam int REG_W  = 5;
    localparam int DATA_W = 16;

    localparam logic [5:0] HDR_LAST  = 6'd13;
    localparam logic [5:0] TA_LAST   = 6'd1;
    localparam logic [5:0] DATA_LAST = 6'd15;

    // Everything after the preamble, MSB first; read frames never drive the TA/data part.
    function automatic logic [31:0] build_frame(
        input logic              wr,
        input logic [PHY_W-1:0]  phy,
        input logic [REG_W-1:0]  regad,
        input logic [DATA_W-1:0] wdata
    );
        return {ST_CODE, (wr ? OP_WR : OP_RD), phy, regad, TA_WR, wdata};
    endfunction

endpackage

// File: rtl/mdio_rr_arb.sv
// rtl/mdio_rr_arb.sv - two-way round-robin arbiter with a held, registered one-hot grant
module mdio_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic [1:0] req,
    output logic [1:0] pick,
    output logic [1:0] gnt
);

    // Index of the requester granted last; starts at 1 so requester 0 wins the first tie.
    logic last;

    always_comb begin
        pick = req;
        if (req == 2'b11) begin
            pick = last ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt  <= 2'b00;
            last <= 1'b1;
        end else if (clr) begin
            gnt <= 2'b00;
        end else if (en && (req != 2'b00)) begin
            gnt  <= pick;
            last <= pick[1];
        end
    end

endmodule

// File: rtl/mdio_master_arb.sv
// rtl/mdio_master_arb.sv - clause-22 MDIO master serving two round-robin requesters
module mdio_master_arb
    import mdio_master_arb_pkg::*;
#(
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        MDC,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_write,
    input  logic [9:0]  req_phy,
    input  logic [9:0]  req_reg,
    input  logic [31:0] req_wdata,
    output logic [1:0]  gnt,
    output logic [1:0]  ack,
    output logic [15:0] rd_data,
    output logic        busy,
    output logic        mdio_out,
    output logic        mdio_oe,
    input  logic        mdio_in
);

    localparam logic [5:0] PRE_LAST = 6'(PREAMBLE_LEN - 1);

    state_t      state;
    logic [5:0]  cnt;
    logic        is_wr;
    logic [31:0] frame;
    logic [15:0] rx;
    logic [1:0]  pick;
    logic        sel;
    logic        arb_en;
    logic        arb_clr;

    assign sel     = pick[1];
    assign arb_en  = (state == S_IDLE);
    assign arb_clr = (state == S_DONE);

    mdio_rr_arb u_arb (
        .clk  (MDC),
        .rst  (rst),
        .en   (arb_en),
        .clr  (arb_clr),
        .req  (req_valid),
        .pick (pick),
        .gnt  (gnt)
    );

    // Line outputs are registered one cycle ahead: each edge loads the bit for the cycle it starts.
    always_ff @(posedge MDC or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= 6'd0;
            is_wr    <= 1'b0;
            frame    <= 32'd0;
            rx       <= 16'd0;
            rd_data  <= 16'd0;
            ack      <= 2'b00;
            busy     <= 1'b0;
            mdio_out <= 1'b1;
            mdio_oe  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid != 2'b00) begin
                        is_wr    <= sel ? req_write[1] : req_write[0];
                        frame    <= build_frame(sel ? req_write[1] : req_write[0],
                                                sel ? req_phy[9:5] : req_phy[4:0],
                                                sel ? req_reg[9:5] : req_reg[4:0],
                                                sel ? req_wdata[31:16] : req_wdata[15:0]);
                        state    <= S_PRE;
                        cnt      <= 6'd0;
                        busy     <= 1'b1;
                        mdio_oe  <= 1'b1;
                        mdio_out <= 1'b1;
                    end
                end
                S_PRE: begin
                    if (cnt == PRE_LAST) begin
                        state    <= S_HDR;
                        cnt      <= 6'd0;
                        mdio_out <= frame[31];
                        frame    <= {frame[30:0], 1'b0};
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                S_HDR: begin
                    frame <= {frame[30:0], 1'b0};
                    if (cnt == HDR_LAST) begin
                        state    <= S_TA;
                        cnt      <= 6'd0;
                        mdio_oe  <= is_wr;
                        mdio_out <= is_wr ? frame[31] : 1'b1;
                    end else begin
                        cnt      <= cnt + 6'd1;
                        mdio_out <= frame[31];
                    end
                end
                S_TA: begin
                    frame    <= {frame[30:0], 1'b0};
                    mdio_out <= is_wr ? frame[31] : 1'b1;
                    if (cnt == TA_LAST) begin
                        state <= S_DATA;
                        cnt   <= 6'd0;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                S_DATA: begin
                    rx <= {rx[14:0], mdio_in};
                    if (cnt == DATA_LAST) begin
                        state    <= S_DONE;
                        ack      <= gnt;
                        mdio_oe  <= 1'b0;
                        mdio_out <= 1'b1;
                        if (!is_wr) begin
                            rd_data <= {rx[14:0], mdio_in};
                        end
                    end else begin
                        cnt      <= cnt + 6'd1;
                        frame    <= {frame[30:0], 1'b0};
                        mdio_out <= is_wr ? frame[31] : 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    ack   <= 2'b00;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_master_arb.sv
// tb/tb_mdio_master_arb.sv - scoreboard bench for mdio_master_arb
module tb_mdio_master_arb;

    logic MDC = 1'b0;
    always #5 MDC = ~MDC;

    logic        rst;
    logic [1:0]  req_valid0, req_valid1;
    logic [1:0]  req_write;
    logic [9:0]  req_phy, req_reg;
    logic [31:0] req_wdata;
    logic        mdio_in;

    logic [1:0]  gnt0, ack0, gnt1, ack1;
    logic [15:0] rd_data0, rd_data1;
    logic        busy0, busy1, mdio_out0, mdio_out1, mdio_oe0, mdio_oe1;

    int checks = 0;
    int errors = 0;
    logic [15:0] last_rd0 = 16'h0;
    logic [15:0] last_rd1 = 16'h0;

    mdio_master_arb #(.PREAMBLE_LEN(32)) dut0 (
        .MDC(MDC), .rst(rst), .req_valid(req_valid0), .req_write(req_write),
        .req_phy(req_phy), .req_reg(req_reg), .req_wdata(req_wdata),
        .gnt(gnt0), .ack(ack0), .rd_data(rd_data0), .busy(busy0),
        .mdio_out(mdio_out0), .mdio_oe(mdio_oe0), .mdio_in(mdio_in)
    );

    mdio_master_arb #(.PREAMBLE_LEN(1)) dut1 (
        .MDC(MDC), .rst(rst), .req_valid(req_valid1), .req_write(req_write),
        .req_phy(req_phy), .req_reg(req_reg), .req_wdata(req_wdata),
        .gnt(gnt1), .ack(ack1), .rd_data(rd_data1), .busy(busy1),
        .mdio_out(mdio_out1), .mdio_oe(mdio_oe1), .mdio_in(mdio_in)
    );

    typedef struct {
        logic [1:0]  g;
        logic [95:0] bits;
        logic [95:0] oe;
        logic [15:0] rd;
        int          p;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t mk_exp(int p, logic [1:0] g, logic wr, logic [4:0] phy,
                                    logic [4:0] rg, logic [15:0] wd, logic [15:0] rd);
        exp_t e;
        logic [31:0] body;
        logic [31:0] boe;
        if (wr) begin
            body = {2'b01, 2'b01, phy, rg, 2'b10, wd};
            boe  = 32'hFFFF_FFFF;
        end else begin
            body = {2'b01, 2'b10, phy, rg, 18'h3FFFF};
            boe  = {14'h3FFF, 18'h0};
        end
        e.bits = '0;
        e.oe   = '0;
        for (int i = 0; i < p; i++) begin
            e.bits[i] = 1'b1;
            e.oe[i]   = 1'b1;
        end
        for (int i = 0; i < 32; i++) begin
            e.bits[p+i] = body[31-i];
            e.oe[p+i]   = boe[31-i];
        end
        e.g  = g;
        e.p  = p;
        e.rd = rd;
        return e;
    endfunction

    function automatic logic [95:0] mask(int p);
        return (96'd1 << (p + 32)) - 96'd1;
    endfunction

    // Waits for a grant, then records one frame cycle by cycle, the ack cycle and the IDLE cycle after it.
    task automatic run_frame(input bit d1, input int p, input logic [15:0] din, input int mode,
                             output int waited, output logic [95:0] bits, output logic [95:0] oe,
                             output logic [1:0] g, output int gbad, output int early,
                             output logic [1:0] a, output logic [15:0] rd, output logic [1:0] gafter);
        waited = 0; bits = '0; oe = '0; g = 2'b00; gbad = 0; early = 0;
        a = 2'b00; rd = 16'h0; gafter = 2'b11;
        do begin
            @(negedge MDC);
            waited++;
            g = d1 ? gnt1 : gnt0;
        end while (g == 2'b00 && waited < 300);
        if (g == 2'b00) return;
        for (int i = 0; i < p + 32; i++) begin
            if (i > 0) @(negedge MDC);
            if (i == 0 && mode >= 1) begin
                if (d1) req_valid1 = 2'b00;
                else    req_valid0 = 2'b00;
            end
            if (i == 0 && mode == 2) begin
                req_write = ~req_write;
                req_phy   = ~req_phy;
                req_reg   = ~req_reg;
                req_wdata = ~req_wdata;
            end
            bits[i] = d1 ? mdio_out1 : mdio_out0;
            oe[i]   = d1 ? mdio_oe1 : mdio_oe0;
            if ((d1 ? gnt1 : gnt0) !== g) gbad++;
            if ((d1 ? ack1 : ack0) !== 2'b00) early++;
            if (i >= p + 16) mdio_in = din[15-(i-p-16)];
        end
        @(negedge MDC);
        mdio_in = 1'b1;
        a  = d1 ? ack1 : ack0;
        rd = d1 ? rd_data1 : rd_data0;
        if ((d1 ? gnt1 : gnt0) !== g) gbad++;
        @(negedge MDC);
        gafter = d1 ? gnt1 : gnt0;
        if ((d1 ? ack1 : ack0) !== 2'b00) early++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge MDC);
        checks++; if (gnt0 !== 2'b00 || ack0 !== 2'b00) begin errors++; $display("FAIL reset_gnt_ack got %b %b want 00 00", gnt0, ack0); end
        checks++; if (busy0 !== 1'b0 || rd_data0 !== 16'h0) begin errors++; $display("FAIL reset_busy_rd got %b %h want 0 0000", busy0, rd_data0); end
        checks++; if (mdio_oe0 !== 1'b0 || mdio_out0 !== 1'b1) begin errors++; $display("FAIL reset_line got oe=%b out=%b want oe=0 out=1", mdio_oe0, mdio_out0); end
        rst = 1'b0;
        @(negedge MDC);
    endtask

    task automatic test_write();
        exp_t e; logic [95:0] b, o, m; logic [1:0] g, a, ga; logic [15:0] r; int w, gb, ea;
        req_write = 2'b01; req_phy = {5'h00, 5'h01}; req_reg = {5'h00, 5'h04};
        req_wdata = {16'h0, 16'hA5C3};
        req_valid0 = 2'b01;
        sb.push_back(mk_exp(32, 2'b01, 1'b1, 5'h01, 5'h04, 16'hA5C3, last_rd0));
        run_frame(1'b0, 32, 16'h0, 1, w, b, o, g, gb, ea, a, r, ga);
        e = sb.pop_front(); m = mask(32);
        checks++; if (g !== e.g) begin errors++; $display("FAIL wr_gnt got %b want %b", g, e.g); end
        checks++; if ((b & m) !== (e.bits & m)) begin errors++; $display("FAIL wr_bits got %h want %h", b & m, e.bits & m); end
        checks++; if ((o & m) !== (e.oe & m)) begin errors++; $display("FAIL wr_oe got %h want %h", o & m, e.oe & m); end
        checks++; if (a !== e.g || ea != 0 || gb != 0) begin errors++; $display("FAIL wr_ack got %b early=%0d gbad=%0d want %b 0 0", a, ea, gb, e.g); end
    endtask

    task automatic test_read();
        exp_t e; logic [95:0] b, o, m; logic [1:0] g, a, ga; logic [15:0] r; int w, gb, ea;
        req_write = 2'b00; req_phy = {5'h1F, 5'h00}; req_reg = {5'h00, 5'h00};
        req_valid0 = 2'b10;
        last_rd0 = 16'h3C0F;
        sb.push_back(mk_exp(32, 2'b10, 1'b0, 5'h1F, 5'h00, 16'h0, last_rd0));
        run_frame(1'b0, 32, 16'h3C0F, 1, w, b, o, g, gb, ea, a, r, ga);
        e = sb.pop_front(); m = mask(32);
        checks++; if ((o & m) !== (e.oe & m)) begin errors++; $display("FAIL rd_oe got %h want %h", o & m, e.oe & m); end
        checks++; if ((b & m) !== (e.bits & m)) begin errors++; $display("FAIL rd_bits got %h want %h", b & m, e.bits & m); end
        checks++; if (a !== e.g || ea != 0) begin errors++; $display("FAIL rd_ack got %b early=%0d want %b", a, ea, e.g); end
        checks++; if (r !== e.rd) begin errors++; $display("FAIL rd_data got %h want %h", r, e.rd); end
    endtask

    task automatic test_back_to_back();
        exp_t e; logic [95:0] b, o, m; logic [1:0] g, a, ga; logic [15:0] r; int w, gb, ea;
        logic [15:0] din_t [3] = '{16'h0, 16'h1234, 16'h0};
        rst = 1'b1; @(negedge MDC); rst = 1'b0;
        last_rd0 = 16'h0;
        req_write = 2'b01; req_phy = {5'h1F, 5'h01}; req_reg = {5'h00, 5'h04};
        req_wdata = {16'h0, 16'hA5C3};
        sb.push_back(mk_exp(32, 2'b01, 1'b1, 5'h01, 5'h04, 16'hA5C3, 16'h0));
        sb.push_back(mk_exp(32, 2'b10, 1'b0, 5'h1F, 5'h00, 16'h0, 16'h1234));
        sb.push_back(mk_exp(32, 2'b01, 1'b1, 5'h01, 5'h04, 16'hA5C3, 16'h1234));
        last_rd0 = 16'h1234;
        req_valid0 = 2'b11;
        m = mask(32);
        for (int k = 0; k < 3; k++) begin
            run_frame(1'b0, 32, din_t[k], 0, w, b, o, g, gb, ea, a, r, ga);
            e = sb.pop_front();
            checks++; if (g !== e.g) begin errors++; $display("FAIL b2b_gnt frame %0d got %b want %b", k, g, e.g); end
            checks++; if (w != 1) begin errors++; $display("FAIL b2b_gap frame %0d got %0d idle cycles+1 want 1", k, w); end
            checks++; if (gb != 0 || ga !== 2'b00) begin errors++; $display("FAIL b2b_gnt_len frame %0d gbad=%0d after=%b want 0 00", k, gb, ga); end
            checks++; if (a !== e.g || ea != 0 || r !== e.rd) begin errors++; $display("FAIL b2b_ack frame %0d got %b %h early=%0d want %b %h", k, a, r, ea, e.g, e.rd); end
            checks++; if ((b & m) !== (e.bits & m) || (o & m) !== (e.oe & m)) begin errors++; $display("FAIL b2b_frame frame %0d got %h want %h", k, b & m, e.bits & m); end
        end
        req_valid0 = 2'b00;
        rst = 1'b1; @(negedge MDC); rst = 1'b0;
        last_rd0 = 16'h0;
    endtask

    task automatic test_reset_mid();
        exp_t e; logic [95:0] b, o, m; logic [1:0] g, a, ga; logic [15:0] r; int w, gb, ea, n;
        req_write = 2'b01; req_phy = {5'h00, 5'h0A}; req_reg = {5'h00, 5'h15};
        req_wdata = {16'h0, 16'h1357};
        req_valid0 = 2'b01;
        n = 0;
        do begin @(negedge MDC); n++; end while (gnt0 == 2'b00 && n < 300);
        checks++; if (gnt0 !== 2'b01) begin errors++; $display("FAIL mid_first_gnt got %b want 01", gnt0); end
        repeat (32 + 7) @(negedge MDC);
        rst = 1'b1;
        #1;
        checks++; if (mdio_oe0 !== 1'b0 || gnt0 !== 2'b00 || busy0 !== 1'b0) begin errors++; $display("FAIL mid_abort got oe=%b gnt=%b busy=%b want 0 00 0", mdio_oe0, gnt0, busy0); end
        for (int k = 0; k < 3; k++) begin
            @(negedge MDC);
            checks++; if (ack0 !== 2'b00) begin errors++; $display("FAIL mid_no_ack got %b want 00", ack0); end
        end
        rst = 1'b0;
        last_rd0 = 16'h0;
        sb.push_back(mk_exp(32, 2'b01, 1'b1, 5'h0A, 5'h15, 16'h1357, last_rd0));
        run_frame(1'b0, 32, 16'h0, 1, w, b, o, g, gb, ea, a, r, ga);
        e = sb.pop_front(); m = mask(32);
        checks++; if (g !== e.g || (b & m) !== (e.bits & m)) begin errors++; $display("FAIL mid_restart got %b %h want %b %h", g, b & m, e.g, e.bits & m); end
        checks++; if (a !== e.g || ea != 0) begin errors++; $display("FAIL mid_restart_ack got %b early=%0d want %b", a, ea, e.g); end
    endtask

    task automatic test_latched_fields();
        exp_t e; logic [95:0] b, o, m; logic [1:0] g, a, ga; logic [15:0] r; int w, gb, ea;
        req_write = 2'b10; req_phy = {5'h12, 5'h00}; req_reg = {5'h0B, 5'h00};
        req_wdata = {16'hC0DE, 16'h0};
        req_valid0 = 2'b10;
        sb.push_back(mk_exp(32, 2'b10, 1'b1, 5'h12, 5'h0B, 16'hC0DE, last_rd0));
        run_frame(1'b0, 32, 16'hFFFF, 2, w, b, o, g, gb, ea, a, r, ga);
        e = sb.pop_front(); m = mask(32);
        checks++; if ((b & m) !== (e.bits & m) || (o & m) !== (e.oe & m)) begin errors++; $display("FAIL latch_frame got %h want %h", b & m, e.bits & m); end
        checks++; if (a !== e.g || r !== e.rd) begin errors++; $display("FAIL latch_ack got %b %h want %b %h", a, r, e.g, e.rd); end
    endtask

    task automatic test_short_preamble();
        exp_t e; logic [95:0] b, o, m; logic [1:0] g, a, ga; logic [15:0] r; int w, gb, ea;
        m = mask(1);
        req_write = 2'b00; req_phy = {5'h00, 5'h03}; req_reg = {5'h00, 5'h02};
        req_valid1 = 2'b01;
        last_rd1 = 16'hBEEF;
        sb.push_back(mk_exp(1, 2'b01, 1'b0, 5'h03, 5'h02, 16'h0, last_rd1));
        run_frame(1'b1, 1, 16'hBEEF, 1, w, b, o, g, gb, ea, a, r, ga);
        e = sb.pop_front();
        checks++; if (a !== e.g || ea != 0 || r !== e.rd) begin errors++; $display("FAIL p1_read got %b %h early=%0d want %b %h", a, r, ea, e.g, e.rd); end
        checks++; if ((o & m) !== (e.oe & m)) begin errors++; $display("FAIL p1_read_oe got %h want %h", o & m, e.oe & m); end
        req_write = 2'b10; req_phy = {5'h04, 5'h00}; req_reg = {5'h07, 5'h00};
        req_wdata = 32'h0;
        req_valid1 = 2'b10;
        sb.push_back(mk_exp(1, 2'b10, 1'b1, 5'h04, 5'h07, 16'h0000, last_rd1));
        run_frame(1'b1, 1, 16'hFFFF, 1, w, b, o, g, gb, ea, a, r, ga);
        e = sb.pop_front();
        checks++; if (a !== e.g || ea != 0) begin errors++; $display("FAIL p1_write_ack got %b early=%0d want %b", a, ea, e.g); end
        checks++; if (r !== e.rd) begin errors++; $display("FAIL p1_rd_hold got %h want %h", r, e.rd); end
        checks++; if ((b & m) !== (e.bits & m) || (o & m) !== (e.oe & m)) begin errors++; $display("FAIL p1_write_frame got %h want %h", b & m, e.bits & m); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid0 = 2'b00; req_valid1 = 2'b00;
        req_write = 2'b00; req_phy = 10'h0; req_reg = 10'h0; req_wdata = 32'h0;
        mdio_in = 1'b1;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid();
        test_latched_fields();
        test_short_preamble();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
